risc_trace_buffer: RTL and testbench

Execution-trace capture stage sitting directly downstream of the 8-bit RISC core. It consumes the core's `pc_counter`, `alu_out` and `halt` outputs, records one entry per program-counter change plus a final halt marker, and buffers the entries in a small FIFO. A host or testbench drains the FIFO through a valid/ready handshake, independently of capture.

---
 rtl/risc_trace_buffer.sv | 157 +++++++++++++++
 tb/tb_risc_trace_buffer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_trace_buffer.sv
// Execution-trace capture FIFO fed by the RISC core's pc/alu/halt outputs.
// Define TRACE_OVERWRITE_EN to overwrite the oldest entry instead of dropping when full.
module risc_trace_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADDR_WIDTH-1:0]              pc_counter,
    input  logic [DATA_WIDTH-1:0]              alu_out,
    input  logic                               halt,
    input  logic                               enable,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ADDR_WIDTH+DATA_WIDTH:0]     out_data,
    output logic [$clog2(DEPTH):0]             level,
    output logic [CNT_WIDTH-1:0]               drop_cnt,
    output logic                               done
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_WIDTH + DATA_WIDTH + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    was_armed_r;
    logic [ADDR_WIDTH-1:0]   pc_q_r;
    logic                    halt_q_r;
    logic [PTR_W-1:0]        wr_ptr_r;
    logic [PTR_W-1:0]        rd_ptr_r;
    logic [LVL_W-1:0]        level_r;
    logic [LVL_W-1:0]        level_nxt_s;
    logic [CNT_WIDTH-1:0]    drop_cnt_r;
    logic                    done_r;
    logic [ENTRY_W-1:0]      mem_r [DEPTH];

    logic                    first_armed_s;
    logic                    marker_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    write_s;
    logic                    lose_s;
    logic                    rd_adv_s;
    logic [ENTRY_W-1:0]      entry_s;

    // Capture FSM: decides whether this cycle produces a trace entry and where to go next.
    always_comb begin
        state_nxt_s   = state_r;
        push_s        = 1'b0;
        marker_s      = 1'b0;
        first_armed_s = (state_r == ST_ARMED) && !was_armed_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_nxt_s = ST_ARMED;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                marker_s = halt && (!halt_q_r || first_armed_s);
                push_s   = first_armed_s || (pc_counter != pc_q_r) || marker_s;
                // The halt marker wins over a simultaneous disarm so the run always terminates in DONE.
                if (marker_s) begin
                    state_nxt_s = ST_DONE;
                end else if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ARMED;
                end
            end
            ST_DONE: begin
                if (!enable) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    assign entry_s = {marker_s, pc_counter, alu_out};
    assign full_s  = (level_r == FULL_LVL);
    assign pop_s   = (level_r != {LVL_W{1'b0}}) && out_ready;

    // FIFO admission: a full FIFO only accepts a push if a pop frees a slot, unless overwriting.
    always_comb begin
        lose_s = push_s && full_s && !pop_s;
`ifdef TRACE_OVERWRITE_EN
        write_s  = push_s;
        rd_adv_s = pop_s || lose_s;
`else
        write_s  = push_s && (!full_s || pop_s);
        rd_adv_s = pop_s;
`endif
        level_nxt_s = level_r + {{(LVL_W-1){1'b0}}, write_s} - {{(LVL_W-1){1'b0}}, rd_adv_s};
    end

    // Control and bookkeeping registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            was_armed_r <= 1'b0;
            pc_q_r      <= {ADDR_WIDTH{1'b0}};
            halt_q_r    <= 1'b0;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= {LVL_W{1'b0}};
            drop_cnt_r  <= {CNT_WIDTH{1'b0}};
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            was_armed_r <= (state_r == ST_ARMED);
            pc_q_r      <= pc_counter;
            halt_q_r    <= halt;
            level_r     <= level_nxt_s;
            done_r      <= (state_nxt_s == ST_DONE);
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (rd_adv_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (lose_s && (drop_cnt_r != {CNT_WIDTH{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage; contents are left as-is on reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r] <= entry_s;
        end
    end

    assign out_data  = mem_r[rd_ptr_r];
    assign out_valid = (level_r != {LVL_W{1'b0}});
    assign level     = level_r;
    assign drop_cnt  = drop_cnt_r;
    assign done      = done_r;

endmodule

// File: tb/tb_risc_trace_buffer.sv
// Self-checking bench for risc_trace_buffer: directed scenarios plus a randomized run
// compared against a queue-based reference model.
module tb_risc_trace_buffer;

    localparam int DW    = 8;
    localparam int AW    = 5;
    localparam int DEPTH = 16;
    localparam int CW    = 8;
    localparam int LW    = 5;
    localparam int EW    = AW + DW + 1;
`ifdef TRACE_OVERWRITE_EN
    localparam int OVR = 1;
`else
    localparam int OVR = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] pc_counter;
    logic [DW-1:0] alu_out;
    logic          halt;
    logic          enable;
    logic          out_valid;
    logic          out_ready;
    logic [EW-1:0] out_data;
    logic [LW-1:0] level;
    logic [CW-1:0] drop_cnt;
    logic          done;

    int total = 0;
    int bad   = 0;

    risc_trace_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .pc_counter(pc_counter), .alu_out(alu_out), .halt(halt),
        .enable(enable), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level), .drop_cnt(drop_cnt), .done(done)
    );

    always #5 clk = ~clk;

    // reference model state
    logic [EW-1:0] q[$];
    int            m_mode;      // 0 idle, 1 armed, 2 done
    bit            m_was_armed;
    bit            m_halt_q;
    logic [AW-1:0] m_pc_q;
    int            m_drop;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
        step();
    endtask

    task automatic model_reset();
        q.delete();
        m_mode      = 0;
        m_was_armed = 1'b0;
        m_halt_q    = 1'b0;
        m_pc_q      = '0;
        m_drop      = 0;
    endtask

    // Applies one clock edge of the specified behaviour, using the inputs currently driven.
    task automatic model_edge();
        bit            pop, push, mark, first;
        logic [EW-1:0] ent, tmp;
        pop  = (q.size() != 0) && out_ready;
        push = 1'b0;
        mark = 1'b0;
        if (m_mode == 1) begin
            first = !m_was_armed;
            mark  = halt && (!m_halt_q || first);
            push  = first || (pc_counter != m_pc_q) || mark;
        end
        ent = {mark, pc_counter, alu_out};
        if (pop) tmp = q.pop_front();
        if (push) begin
            if (q.size() < DEPTH) begin
                q.push_back(ent);
            end else begin
                if (OVR == 1) begin
                    tmp = q.pop_front();
                    q.push_back(ent);
                end
                if (m_drop < 255) m_drop++;
            end
        end
        m_was_armed = (m_mode == 1);
        case (m_mode)
            0: if (enable) m_mode = 1;
            1: if (mark) m_mode = 2; else if (!enable) m_mode = 0;
            default: if (!enable) m_mode = 0;
        endcase
        m_pc_q   = pc_counter;
        m_halt_q = halt;
    endtask

    task automatic test_reset();
        rst = 1'b0; enable = 1'b0; halt = 1'b0; out_ready = 1'b0;
        pc_counter = '0; alu_out = '0;
        step(); step();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", done); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_capture_and_halt();
        logic [AW-1:0] pcs [5] = '{5'd0, 5'd1, 5'd2, 5'd2, 5'd3};
        logic [EW-1:0] exp_q[$];
        logic [DW-1:0] a;
        enable = 1'b1; pc_counter = 5'd0;
        step();
        for (int i = 0; i < 5; i++) begin
            a = DW'($urandom);
            pc_counter = pcs[i]; alu_out = a;
            if (i != 3) exp_q.push_back({1'b0, pcs[i], a});
            step();
        end
        total++; if (level !== 5'd4) begin bad++; $display("FAIL cap_level got=%0d exp=4", level); end
        total++; if (drop_cnt !== 8'd0) begin bad++; $display("FAIL cap_drop got=%0d exp=0", drop_cnt); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL cap_done got=%0b exp=0", done); end
        a = DW'($urandom);
        pc_counter = 5'd4; alu_out = a; halt = 1'b1;
        exp_q.push_back({1'b1, 5'd4, a});
        step();
        total++; if (done !== 1'b1) begin bad++; $display("FAIL halt_done got=%0b exp=1", done); end
        total++; if (level !== 5'd5) begin bad++; $display("FAIL halt_level got=%0d exp=5", level); end
        pc_counter = 5'd5; step();
        pc_counter = 5'd6; step();
        total++; if (level !== 5'd5) begin bad++; $display("FAIL post_halt_level got=%0d exp=5", level); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL post_halt_done got=%0b exp=1", done); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++; if (out_data !== exp_q[i]) begin bad++; $display("FAIL cap_pop%0d got=%h exp=%h", i, out_data, exp_q[i]); end
            step();
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL drained_valid got=%0b exp=0", out_valid); end
        out_ready = 1'b0; enable = 1'b0; halt = 1'b0;
        step();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL idle_done got=%0b exp=0", done); end
    endtask

    task automatic test_full_then_push_pop();
        int first_pc;
        do_reset();
        enable = 1'b1; out_ready = 1'b0; halt = 1'b0; pc_counter = 5'd0;
        step();
        for (int i = 0; i < 20; i++) begin
            pc_counter = AW'(i); alu_out = DW'(i + 100);
            step();
        end
        first_pc = (OVR == 1) ? 4 : 0;
        total++; if (level !== 5'd16) begin bad++; $display("FAIL full_level got=%0d exp=16", level); end
        total++; if (drop_cnt !== 8'd4) begin bad++; $display("FAIL full_drop got=%0d exp=4", drop_cnt); end
        total++; if (out_data !== {1'b0, AW'(first_pc), DW'(first_pc + 100)}) begin
            bad++; $display("FAIL full_head got=%h exp_pc=%0d", out_data, first_pc); end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc_counter = AW'(20 + i); alu_out = DW'(120 + i);
            total++; if (out_data[DW +: AW] !== AW'(first_pc + i)) begin
                bad++; $display("FAIL fullpp_order%0d got=%0d exp=%0d", i, out_data[DW +: AW], first_pc + i); end
            step();
            total++; if (level !== 5'd16) begin bad++; $display("FAIL fullpp_level%0d got=%0d exp=16", i, level); end
        end
        total++; if (drop_cnt !== 8'd4) begin bad++; $display("FAIL fullpp_drop got=%0d exp=4", drop_cnt); end
        out_ready = 1'b0; enable = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1; out_ready = 1'b0; pc_counter = 5'd1;
        step();
        for (int i = 1; i <= 7; i++) begin
            pc_counter = AW'(i);
            step();
        end
        total++; if (level !== 5'd7) begin bad++; $display("FAIL mid_level_pre got=%0d exp=7", level); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b exp=0", out_valid); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL mid_level got=%0d exp=0", level); end
        enable = 1'b0;
        rst = 1'b1;
        step();
    endtask

    task automatic test_rearm();
        do_reset();
        enable = 1'b1; out_ready = 1'b0; pc_counter = 5'd1;
        step();
        step();
        pc_counter = 5'd2; step();
        enable = 1'b0; step();
        pc_counter = 5'd9; step();
        pc_counter = 5'd10; step();
        total++; if (level !== 5'd2) begin bad++; $display("FAIL rearm_idle_level got=%0d exp=2", level); end
        enable = 1'b1; step(); step(); step();
        total++; if (level !== 5'd3) begin bad++; $display("FAIL rearm_level got=%0d exp=3", level); end
        out_ready = 1'b1;
        total++; if (out_data[DW +: AW] !== 5'd1) begin bad++; $display("FAIL rearm_pop0 got=%0d exp=1", out_data[DW +: AW]); end
        step();
        total++; if (out_data[DW +: AW] !== 5'd2) begin bad++; $display("FAIL rearm_pop1 got=%0d exp=2", out_data[DW +: AW]); end
        step();
        total++; if (out_data[DW +: AW] !== 5'd10) begin bad++; $display("FAIL rearm_pop2 got=%0d exp=10", out_data[DW +: AW]); end
        step();
        out_ready = 1'b0; enable = 1'b0;
        step();
    endtask

    task automatic test_random();
        int nprint = 0;
        do_reset();
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            enable    = ($urandom_range(0, 99) < 95);
            if ($urandom_range(0, 99) < 60) pc_counter = AW'($urandom);
            alu_out   = DW'($urandom);
            if ($urandom_range(0, 99) < 8) halt = ~halt;
            out_ready = ($urandom_range(0, 99) < (((i / 400) % 2 == 1) ? 80 : 15));
            model_edge();
            step();
            total++; if (level !== LW'(q.size()) || out_valid !== (q.size() != 0)) begin
                bad++; if (nprint < 20) $display("FAIL rnd_level cyc=%0d got=%0d/%0b exp=%0d", i, level, out_valid, q.size()); nprint++; end
            total++; if (drop_cnt !== CW'(m_drop)) begin
                bad++; if (nprint < 20) $display("FAIL rnd_drop cyc=%0d got=%0d exp=%0d", i, drop_cnt, m_drop); nprint++; end
            total++; if (done !== (m_mode == 2)) begin
                bad++; if (nprint < 20) $display("FAIL rnd_done cyc=%0d got=%0b exp=%0b", i, done, m_mode == 2); nprint++; end
            if (q.size() != 0) begin
                total++; if (out_data !== q[0]) begin
                    bad++; if (nprint < 20) $display("FAIL rnd_data cyc=%0d got=%h exp=%h", i, out_data, q[0]); nprint++; end
            end
        end
    endtask

    initial begin
        test_reset();
        test_capture_and_halt();
        test_full_then_push_pop();
        test_reset_mid();
        test_rearm();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
